// File: rtl/tc_ram_pkg.sv
// tc_ram_pkg: shared types and constants for the tc_ram_multi RAM slice.
//   state_e    - controller states (sweep-clear / normal operation)
//   BYTE_W     - width of one byte lane
//   mask_width - byte-mask width derived from a data width
package tc_ram_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic int unsigned mask_width(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/tc_ram_array.sv
// tc_ram_array: plain storage, one byte-masked write port, two registered
// read ports. No reset on the array or the read registers so the tool can
// map it onto block RAM.
//   clk            posedge clock
//   we/waddr       write enable / address
//   wmask/wdata    byte enables / write data
//   reN/raddrN     read enable / address, port N
//   rdataN         registered read data, port N (read-first on collision)
module tc_ram_array
  import tc_ram_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned ADDR_W = 8,
  localparam int unsigned MASK_W = mask_width(WIDTH),
  localparam int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [MASK_W-1:0] wmask,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re0,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [WIDTH-1:0]  rdata0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata0_q;
  logic [WIDTH-1:0] rdata1_q;

  // Reads use the pre-edge contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < MASK_W; i++) begin
        if (wmask[i]) begin
          mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
    if (re0) rdata0_q <= mem[raddr0];
    if (re1) rdata1_q <= mem[raddr1];
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: rtl/tc_ram_multi.sv
// tc_ram_multi: single-write, dual-read synchronous RAM with byte masks and a
// sequenced zeroing sweep after reset or on a clear request.
//   clk              posedge clock
//   rst              asynchronous active-low reset
//   clear / busy     re-zero request (IDLE only) / sweep in progress
//   loadN/addressN   read enable / address, port N; outN is 0 when not loaded
//   outN             read data, port N, one cycle after the load
//   save/save_addr   write enable / address
//   mask/in          byte enables / write data
module tc_ram_multi
  import tc_ram_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned ADDR_W = 8,
  localparam int unsigned MASK_W = mask_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic              load0,
  input  logic [ADDR_W-1:0] address0,
  output logic [WIDTH-1:0]  out0,
  input  logic              load1,
  input  logic [ADDR_W-1:0] address1,
  output logic [WIDTH-1:0]  out1,
  input  logic              save,
  input  logic [ADDR_W-1:0] save_addr,
  input  logic [MASK_W-1:0] mask,
  input  logic [WIDTH-1:0]  in
);

  localparam logic [ADDR_W:0] PTR_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              rd_v0_q, rd_v0_d;
  logic              rd_v1_q, rd_v1_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MASK_W-1:0] wr_mask;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  rdata0, rdata1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rd_v0_d = 1'b0;
    rd_v1_d = 1'b0;
    wr_en   = 1'b0;
    wr_addr = save_addr;
    wr_mask = mask;
    wr_data = in;
    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q[ADDR_W-1:0];
        wr_mask = '1;
        wr_data = '0;
        ptr_d   = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          wr_en   = save;
          rd_v0_d = load0;
          rd_v1_d = load1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      rd_v0_q <= 1'b0;
      rd_v1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd_v0_q <= rd_v0_d;
      rd_v1_q <= rd_v1_d;
    end
  end

  // The array has no reset, so the sweep write is held off while rst is low
  // to leave its contents untouched during reset.
  tc_ram_array #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en & rst),
    .waddr (wr_addr),
    .wmask (wr_mask),
    .wdata (wr_data),
    .re0   (rd_v0_d),
    .raddr0(address0),
    .rdata0(rdata0),
    .re1   (rd_v1_d),
    .raddr1(address1),
    .rdata1(rdata1)
  );

  assign busy = (state_q == ST_CLEAR);
  assign out0 = rd_v0_q ? rdata0 : '0;
  assign out1 = rd_v1_q ? rdata1 : '0;

endmodule

// File: tb/tb_tc_ram_multi.sv
// tb_tc_ram_multi: directed + randomized bench for tc_ram_multi
// (WIDTH=16, ADDR_W=4), checked against a word-array reference model.
module tb_tc_ram_multi;

  localparam int unsigned W     = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          busy;
  logic          load0 = 1'b0, load1 = 1'b0, save = 1'b0;
  logic [AW-1:0] address0 = '0, address1 = '0, save_addr = '0;
  logic [W-1:0]  out0, out1;
  logic [1:0]    mask = '0;
  logic [W-1:0]  din = '0;

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array plus a busy flag and sweep position.
  logic [W-1:0] mem_m [DEPTH];
  bit           m_busy = 1'b1;
  int           m_ptr  = 0;

  tc_ram_multi #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .busy     (busy),
    .load0    (load0),
    .address0 (address0),
    .out0     (out0),
    .load1    (load1),
    .address1 (address1),
    .out1     (out1),
    .save     (save),
    .save_addr(save_addr),
    .mask     (mask),
    .in       (din)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict the effect of the current inputs at the next edge, advance one
  // cycle, then compare at #1 after the edge.
  task automatic tick();
    logic [W-1:0] n0, n1;
    n0 = '0;
    n1 = '0;
    if (!rst) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end else if (m_busy) begin
      mem_m[m_ptr] = '0;
      m_ptr++;
      if (m_ptr == DEPTH) m_busy = 1'b0;
    end else if (clear) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end else begin
      if (load0) n0 = mem_m[address0];
      if (load1) n1 = mem_m[address1];
      if (save) begin
        for (int b = 0; b < 2; b++) begin
          if (mask[b]) mem_m[save_addr][b*8 +: 8] = din[b*8 +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    check("out0", {16'h0, out0}, {16'h0, n0});
    check("out1", {16'h0, out1}, {16'h0, n1});
    check("busy", {31'h0, busy}, {31'h0, m_busy});
  endtask

  task automatic idle_inputs();
    clear = 1'b0; load0 = 1'b0; load1 = 1'b0; save = 1'b0; mask = '0;
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
    check(tag, cnt, DEPTH);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      load0 = 1'b1; address0 = AW'(i);
      load1 = 1'b1; address1 = AW'(DEPTH - 1 - i);
      tick();
      check(tag, {16'h0, out0 | out1}, 32'h0);
    end
    idle_inputs();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [1:0] m);
    save = 1'b1; save_addr = a; din = d; mask = m;
    tick();
    save = 1'b0; mask = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

    // Reset state.
    #1;
    check("rst_out0", {16'h0, out0}, 32'h0);
    check("rst_out1", {16'h0, out1}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
    tick();
    tick();

    // Sweep after reset release.
    rst = 1'b1;
    count_busy("sweep_len");
    read_all_zero("sweep_zero");

    // Masked write.
    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    load0 = 1'b1; address0 = 4'd3;
    tick();
    check("masked_rd", {16'h0, out0}, 32'h0000AB34);
    idle_inputs();
    wr(4'd6, 16'hFFFF, 2'b00);
    load0 = 1'b1; address0 = 4'd6;
    tick();
    check("mask_zero_noop", {16'h0, out0}, 32'h0);
    idle_inputs();

    // Read-first collision.
    wr(4'd5, 16'h0011, 2'b11);
    save = 1'b1; save_addr = 4'd5; din = 16'h0022; mask = 2'b11;
    load0 = 1'b1; address0 = 4'd5; load1 = 1'b1; address1 = 4'd5;
    tick();
    check("coll_out0", {16'h0, out0}, 32'h11);
    check("coll_out1", {16'h0, out1}, 32'h11);
    save = 1'b0;
    tick();
    check("coll_new0", {16'h0, out0}, 32'h22);
    check("coll_new1", {16'h0, out1}, 32'h22);
    idle_inputs();

    // Load gating.
    wr(4'd2, 16'h007E, 2'b11);
    wr(4'd4, 16'h5A5A, 2'b11);
    load0 = 1'b1; address0 = 4'd2; load1 = 1'b1; address1 = 4'd4;
    tick();
    check("gate_on", {16'h0, out0}, 32'h7E);
    load0 = 1'b0;
    tick();
    check("gate_off", {16'h0, out0}, 32'h0);
    check("gate_out1", {16'h0, out1}, 32'h5A5A);
    idle_inputs();

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 300; n++) begin
      clear     = ($urandom_range(0, 59) == 0);
      load0     = 1'($urandom);
      load1     = 1'($urandom);
      save      = 1'($urandom);
      address0  = AW'($urandom);
      address1  = AW'($urandom);
      save_addr = AW'($urandom);
      mask      = 2'($urandom);
      din       = W'($urandom);
      tick();
    end
    idle_inputs();
    while (m_busy) tick();

    // Clear pulse with a same-cycle save, saves during the sweep dropped.
    wr(4'd9, 16'hBEEF, 2'b11);
    clear = 1'b1; save = 1'b1; save_addr = 4'd9; din = 16'h1111; mask = 2'b11;
    tick();
    clear = 1'b0;
    save_addr = 4'd1; din = 16'hC0DE;
    count_busy("clear_len");
    idle_inputs();
    read_all_zero("clear_zero");

    // Reset mid-sweep.
    wr(4'd12, 16'h4321, 2'b11);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    load0 = 1'b1; load1 = 1'b1; save = 1'b1; mask = 2'b11;
    rst = 1'b0;
    #1;
    check("mid_rst_out0", {16'h0, out0}, 32'h0);
    check("mid_rst_out1", {16'h0, out1}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h1);
    tick();
    tick();
    idle_inputs();
    rst = 1'b1;
    count_busy("rst_sweep_len");
    read_all_zero("rst_sweep_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
